// File: rtl/led_secuenciador_if.sv
// Board-side bundle for the LED sequencer: switch inputs towards the sequencer,
// LED drive, step strobe and position back towards the board.
interface led_secuenciador_if #(
    parameter int N_LEDS = 4
) ();
    logic                            dir;
    logic [1:0]                      mode;
    logic                            pause;
    logic [N_LEDS-1:0]               leds;
    logic                            tick;
    logic [$clog2(N_LEDS+1)-1:0]     pos;

    modport master (output dir, output mode, output pause,
                    input  leds, input tick, input pos);
    modport slave  (input  dir, input mode, input pause,
                    output leds, output tick, output pos);
endinterface

// File: rtl/led_secuenciador.sv
// Parametrised LED pattern sequencer: rotate, bounce, fill bar and blink patterns
// stepped by a prescaler, with synchronised switch inputs and a pause control.
module led_secuenciador #(
    parameter int N_LEDS      = 4,
    parameter int DIV         = 25000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    led_secuenciador_if.slave   bus
);
    localparam int PW = $clog2(N_LEDS + 1);
    localparam int CW = $clog2(DIV);
    localparam logic [PW-1:0] POS_ZERO   = PW'(0);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [PW-1:0] POS_LAST   = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_PREV   = PW'(N_LEDS - 2);
    localparam logic [PW-1:0] POS_FULL   = PW'(N_LEDS);
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    logic [SYNC_STAGES-1:0] dir_sync_r;
    logic [SYNC_STAGES-1:0] pause_sync_r;
    logic [1:0]             mode_sync_r [SYNC_STAGES];
    logic                   dir_s;
    logic                   pause_s;
    mode_e                  mode_s;

    logic [CW-1:0]          presc_r, presc_n_s;
    logic                   step_s;
    mode_e                  mode_q_r, mode_q_n_s;
    logic                   bounce_up_r, bounce_up_n_s;
    logic [PW-1:0]          pos_r, pos_n_s;
    logic [N_LEDS-1:0]      leds_r, leds_n_s;
    logic                   tick_r;

    function automatic logic [N_LEDS-1:0] one_hot(input logic [PW-1:0] p);
        logic [N_LEDS-1:0] r;
        for (int i = 0; i < N_LEDS; i++) begin
            r[i] = (p == PW'(i));
        end
        return r;
    endfunction

    // Thermometer code: the lowest 'level' LEDs lit.
    function automatic logic [N_LEDS-1:0] fill_bar(input logic [PW-1:0] level);
        logic [N_LEDS-1:0] r;
        for (int i = 0; i < N_LEDS; i++) begin
            r[i] = (PW'(i) < level);
        end
        return r;
    endfunction

    assign dir_s   = dir_sync_r[SYNC_STAGES-1];
    assign pause_s = pause_sync_r[SYNC_STAGES-1];
    assign mode_s  = mode_e'(mode_sync_r[SYNC_STAGES-1]);

    // Switch input synchronizer chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_sync_r   <= {SYNC_STAGES{1'b0}};
            pause_sync_r <= {SYNC_STAGES{1'b0}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                mode_sync_r[i] <= 2'b00;
            end
        end else begin
            dir_sync_r[0]   <= bus.dir;
            pause_sync_r[0] <= bus.pause;
            mode_sync_r[0]  <= bus.mode;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dir_sync_r[i]   <= dir_sync_r[i-1];
                pause_sync_r[i] <= pause_sync_r[i-1];
                mode_sync_r[i]  <= mode_sync_r[i-1];
            end
        end
    end

    // Prescaler next value and step condition; pause freezes the count.
    always_comb begin
        presc_n_s = presc_r;
        step_s    = 1'b0;
        if (pause_s) begin
            presc_n_s = presc_r;
        end else if (presc_r == PRESC_LAST) begin
            presc_n_s = {CW{1'b0}};
            step_s    = 1'b1;
        end else begin
            presc_n_s = presc_r + CW'(1);
        end
    end

    // Pattern next state: reload on a mode change, otherwise advance the current mode.
    always_comb begin
        mode_q_n_s    = mode_q_r;
        bounce_up_n_s = bounce_up_r;
        pos_n_s       = pos_r;
        leds_n_s      = leds_r;
        if (!step_s) begin
            mode_q_n_s = mode_q_r;
        end else if (mode_s != mode_q_r) begin
            mode_q_n_s = mode_s;
            pos_n_s    = POS_ZERO;
            case (mode_s)
                MODE_ROTATE: leds_n_s = one_hot(POS_ZERO);
                MODE_BOUNCE: begin
                    leds_n_s      = one_hot(POS_ZERO);
                    bounce_up_n_s = 1'b1;
                end
                MODE_FILL:   leds_n_s = {N_LEDS{1'b0}};
                MODE_BLINK:  leds_n_s = {N_LEDS{1'b1}};
                default:     leds_n_s = one_hot(POS_ZERO);
            endcase
        end else begin
            case (mode_q_r)
                MODE_ROTATE: begin
                    if (dir_s) begin
                        pos_n_s = (pos_r == POS_LAST) ? POS_ZERO : pos_r + POS_ONE;
                    end else begin
                        pos_n_s = (pos_r == POS_ZERO) ? POS_LAST : pos_r - POS_ONE;
                    end
                    leds_n_s = one_hot(pos_n_s);
                end
                MODE_BOUNCE: begin
                    // Turn around at the ends so the end LED is lit for one step only.
                    if (bounce_up_r) begin
                        if (pos_r == POS_LAST) begin
                            pos_n_s       = POS_PREV;
                            bounce_up_n_s = 1'b0;
                        end else begin
                            pos_n_s = pos_r + POS_ONE;
                        end
                    end else begin
                        if (pos_r == POS_ZERO) begin
                            pos_n_s       = POS_ONE;
                            bounce_up_n_s = 1'b1;
                        end else begin
                            pos_n_s = pos_r - POS_ONE;
                        end
                    end
                    leds_n_s = one_hot(pos_n_s);
                end
                MODE_FILL: begin
                    if (dir_s) begin
                        pos_n_s = (pos_r == POS_FULL) ? POS_ZERO : pos_r + POS_ONE;
                    end else begin
                        pos_n_s = (pos_r == POS_ZERO) ? POS_FULL : pos_r - POS_ONE;
                    end
                    leds_n_s = fill_bar(pos_n_s);
                end
                MODE_BLINK: begin
                    pos_n_s  = POS_ZERO;
                    leds_n_s = ~leds_r;
                end
                default: begin
                    pos_n_s  = POS_ZERO;
                    leds_n_s = one_hot(POS_ZERO);
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r     <= {CW{1'b0}};
            mode_q_r    <= MODE_ROTATE;
            bounce_up_r <= 1'b1;
            pos_r       <= POS_ZERO;
            leds_r      <= {{(N_LEDS-1){1'b0}}, 1'b1};
            tick_r      <= 1'b0;
        end else begin
            presc_r     <= presc_n_s;
            mode_q_r    <= mode_q_n_s;
            bounce_up_r <= bounce_up_n_s;
            pos_r       <= pos_n_s;
            leds_r      <= leds_n_s;
            tick_r      <= step_s;
        end
    end

    assign bus.leds = leds_r;
    assign bus.pos  = pos_r;
    assign bus.tick = tick_r;

endmodule

// File: doc/led_secuenciador.md
Name: led_secuenciador

Overview:
- Parametrised LED pattern sequencer; next generation of the fixed 4-LED direction-controlled shifter.
- Generalises LED count and step rate, and adds selectable patterns (rotate, bounce, fill bar, blink), pause, a step strobe and a position output.
- Sits between board switches (dir, mode, pause) and the LED bank.
- All logic runs in one clock domain.

Parameters:
N_LEDS, 4, number of LEDs driven (min 2)
DIV, 25000000, clk cycles per pattern step (min 2)
SYNC_STAGES, 2, flip-flop stages on dir, mode and pause inputs (min 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
dir  input  1  1 = move toward MSB / fill up; 0 = toward LSB / empty down (async switch)
mode  input  2  00 rotate, 01 bounce, 10 fill bar, 11 blink (async switch)
pause  input  1  1 freezes the prescaler and pattern (async switch)
leds  output  N_LEDS  LED drive, registered
tick  output  1  one-cycle strobe on each pattern step, registered
pos  output  clog2(N_LEDS+1)  current position (rotate/bounce) or fill level (fill), 0 in blink

Behaviour:
- Reset (rst_n low, asynchronous):
  - leds = 1 (bit0 only), tick = 0, pos = 0
  - prescaler = 0, mode_q = 00, bounce_up = 1, synchronizer flops = 0
  - Release is sampled on the first clk rising edge with rst_n high.
- Input synchronizers:
  - dir, mode and pause each pass through SYNC_STAGES flops.
  - All internal logic uses only the synchronized versions.
  - Input-to-effect latency is SYNC_STAGES cycles plus the wait for the next tick.
- Prescaler:
  - Counts 0..DIV-1, wraps to 0.
  - Step condition: prescaler == DIV-1 and pause_s = 0.
  - tick is asserted in the cycle after the step condition, for exactly one cycle, aligned with the new leds value.
  - While pause_s = 1: prescaler holds its value, no ticks, leds and pos hold.
  - On pause release, counting resumes from the held value, with no extra or lost step.
- Mode change:
  - mode_s is compared with mode_q only at a step.
  - If they differ: mode_q <= mode_s and the pattern loads the new mode's initial value instead of advancing.
  - Initial values:
    - rotate: leds = bit0, pos = 0
    - bounce: leds = bit0, pos = 0, bounce_up = 1
    - fill: level 0, leds = all 0
    - blink: leds = all 1
- Step rules, when mode is unchanged:
  - Rotate: dir_s = 1 gives pos = pos+1 with N_LEDS-1 wrapping to 0; dir_s = 0 gives pos-1 with 0 wrapping to N_LEDS-1. leds is one-hot at pos.
  - Bounce: dir_s is ignored. If bounce_up, pos+1; at pos = N_LEDS-1 the step goes to N_LEDS-2 and clears bounce_up. Mirror rule at pos = 0. The end LED is lit for exactly one step, with no double-dwell.
  - Fill: level runs 0..N_LEDS and leds = (1<<level)-1.
    - dir_s = 1: level+1, with N_LEDS wrapping to 0.
    - dir_s = 0: level-1, with 0 wrapping to N_LEDS.
    - pos = level.
  - Blink: leds <= ~leds, so all-1 and all-0 alternate. pos = 0.
- Direction change takes effect on the next step from the current position, with no jump or reload.
- Widths:
  - pos arithmetic is done at clog2(N_LEDS+1) bits.
  - Wrap is by explicit compare, never by natural overflow, so non-power-of-two N_LEDS is correct.
- Reset mid-pattern or while paused returns everything to the reset values immediately, regardless of clk.

Test Plan:
- N_LEDS=4, DIV=4, mode=00, dir=1, pause=0, release reset: leds = 0001, then 0010, 0100, 1000, 0001 on successive ticks, ticks 4 cycles apart, each tick one cycle wide.
- Same setup, dir=0 after leds = 0100: the next steps are 0010, 0001, 1000. The dir change applies no earlier than SYNC_STAGES cycles after the toggle.
- N_LEDS=5, mode=01: leds sequence 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010. pos follows 0..4..0; toggling dir has no effect.
- N_LEDS=4, mode=10, dir=1: 0000, 0001, 0011, 0111, 1111, 0000 with pos 0..4. With dir=0 from 0000 the next step is 1111.
- Mode switch 00 to 11 at leds = 0100: the next step loads 1111, then 0000, 1111.
- pause=1 at prescaler = 2: no tick, leds held for 20 cycles. After release, the next tick arrives exactly DIV-2 cycles after pause_s falls.
- Assert rst_n=0 mid-cycle while paused: leds = 0001, tick = 0 and pos = 0 immediately, without a clk edge.
